// File: rtl/alu_pkg.sv
// Shared constants and width helpers for the operand-selector datapath.
package alu_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Select/index width: at least one bit even for a single channel
  function automatic int sel_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Increment a channel index with wrap back to zero at k
  function automatic int wrap_inc(input int i, input int k);
    return (i + 1 >= k) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-from-pointer: returns the first requesting channel
// at or after ptr, wrapping modulo K.
module rr_pick
  import alu_pkg::*;
#(
  parameter  int K  = 4,
  localparam int SW = sel_width(K)
) (
  input  logic [K-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  int   idx;
  logic found;

  assign any = |req;

  // Scan K positions starting at ptr and keep the first requester seen
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int j = 0; j < K; j++) begin
      idx = (int'(ptr) + j) % K;
      if (!found && req[idx]) begin
        gnt_idx = SW'(idx);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Registered K-to-1 operand selector with valid/ready on every channel and on
// the output. MODE_SEL picks the channel from C; MODE_RR arbitrates round-robin
// over the valid channels and ignores C.
module mux_nto1_pipe
  import alu_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int K    = 4,
  parameter  int MODE = MODE_SEL,
  localparam int SW   = sel_width(K)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [K*N-1:0] X,
  input  logic [K-1:0]   XV,
  output logic [K-1:0]   XR,
  input  logic [SW-1:0]  C,
  output logic [N-1:0]   R,
  output logic           RV,
  input  logic           RR,
  output logic [SW-1:0]  RI
);

  logic [SW-1:0] sel;
  logic [SW-1:0] sel_safe;
  logic          sel_ok;
  logic          space;
  logic          load;
  logic [N-1:0]  data_p0;

  logic [N-1:0]  data_p1;
  logic [SW-1:0] idx_p1;
  logic          vld_p1;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] ptr;
      logic [SW-1:0] gnt_idx;
      logic          any;

      rr_pick #(.K(K)) u_pick (
        .req     (XV),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .any     (any)
      );

      assign sel    = gnt_idx;
      assign sel_ok = any;

      // Fairness pointer: next search starts just past the channel that was served
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          ptr <= '0;
        end else if (load) begin
          ptr <= SW'(wrap_inc(int'(gnt_idx), K));
        end
      end
    end else begin : g_sel
      // A single channel always selects index 0; C only qualifies the request
      assign sel    = (K == 1) ? '0 : C;
      assign sel_ok = (int'(C) < K);
    end
  endgenerate

  // Stage p0: handshake decode and input selection
  always_comb begin
    sel_safe = sel_ok ? sel : '0;
    data_p0  = X[int'(sel_safe)*N +: N];
    space    = !vld_p1 || RR;
    load     = RST_N && space && sel_ok && XV[sel_safe];
    XR       = '0;
    if (RST_N && space && sel_ok) begin
      XR[sel_safe] = 1'b1;
    end
  end

  // Stage p1: output register; loads, drains, or holds under backpressure
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      idx_p1  <= sel_safe;
    end else if (RR) begin
      vld_p1  <= 1'b0;
    end
  end

  assign R  = data_p1;
  assign RV = vld_p1;
  assign RI = idx_p1;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: three instances (K=4 select mode, K=3 select mode,
// K=4 round-robin mode) driven by directed vectors; expected outputs are queued
// at issue time and popped by per-instance monitors on each accepted output.
module tb_mux_nto1_pipe;

  localparam int N = 32;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  i;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: K=4, select mode
  logic [4*N-1:0] x_a;
  logic [3:0]     xv_a, xr_a;
  logic [1:0]     c_a, ri_a;
  logic [N-1:0]   r_a;
  logic           rv_a, rr_a;

  // Instance b: K=3, select mode
  logic [3*N-1:0] x_b;
  logic [2:0]     xv_b, xr_b;
  logic [1:0]     c_b, ri_b;
  logic [N-1:0]   r_b;
  logic           rv_b, rr_b;

  // Instance m: K=4, round-robin mode
  logic [4*N-1:0] x_m;
  logic [3:0]     xv_m, xr_m;
  logic [1:0]     c_m, ri_m;
  logic [N-1:0]   r_m;
  logic           rv_m, rr_m;

  int total = 0;
  int bad   = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_m[$];

  mux_nto1_pipe #(.N(N), .K(4), .MODE(0)) u_a (
    .CLK(clk), .RST_N(rst_n), .X(x_a), .XV(xv_a), .XR(xr_a), .C(c_a),
    .R(r_a), .RV(rv_a), .RR(rr_a), .RI(ri_a)
  );

  mux_nto1_pipe #(.N(N), .K(3), .MODE(0)) u_b (
    .CLK(clk), .RST_N(rst_n), .X(x_b), .XV(xv_b), .XR(xr_b), .C(c_b),
    .R(r_b), .RV(rv_b), .RR(rr_b), .RI(ri_b)
  );

  mux_nto1_pipe #(.N(N), .K(4), .MODE(1)) u_m (
    .CLK(clk), .RST_N(rst_n), .X(x_m), .XV(xv_m), .XR(xr_m), .C(c_m),
    .R(r_m), .RV(rv_m), .RR(rr_m), .RI(ri_m)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitors: an output is consumed when RV and RR are both high at the edge
  always @(negedge clk) begin
    if (rst_n && rv_a && rr_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected: got R=%0h RI=%0d with nothing expected", r_a, ri_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_data", 64'(r_a), 64'(e.d));
        chk("a_idx", 64'(ri_a), 64'(e.i));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rv_b && rr_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got R=%0h RI=%0d with nothing expected", r_b, ri_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_data", 64'(r_b), 64'(e.d));
        chk("b_idx", 64'(ri_b), 64'(e.i));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rv_m && rr_m) begin
      if (q_m.size() == 0) begin
        total++; bad++;
        $display("FAIL m_unexpected: got R=%0h RI=%0d with nothing expected", r_m, ri_m);
      end else begin
        exp_t e;
        e = q_m.pop_front();
        chk("m_data", 64'(r_m), 64'(e.d));
        chk("m_idx", 64'(ri_m), 64'(e.i));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;

    // Reset held two cycles with every channel requesting
    x_a = '0; xv_a = 4'hF; c_a = 2'd2; rr_a = 1'b1;
    x_b = '0; xv_b = 3'b111; c_b = 2'd0; rr_b = 1'b1;
    x_m = '0; xv_m = 4'hF; c_m = 2'd0; rr_m = 1'b1;
    #1;
    chk("rst_xr_a_pre", 64'(xr_a), 64'h0);
    chk("rst_xr_m_pre", 64'(xr_m), 64'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_rv_a", 64'(rv_a), 64'h0);
      chk("rst_r_a", 64'(r_a), 64'h0);
      chk("rst_ri_a", 64'(ri_a), 64'h0);
      chk("rst_xr_a", 64'(xr_a), 64'h0);
      chk("rst_rv_m", 64'(rv_m), 64'h0);
      chk("rst_xr_m", 64'(xr_m), 64'h0);
    end
    xv_a = 4'h0; xv_b = 3'b000; xv_m = 4'h0;
    rst_n = 1'b1;
    tick();

    // Select mode: single transfer then a back-to-back stream on channel 1
    c_a = 2'd2; xv_a = 4'b0100; x_a[2*N +: N] = 32'hDEAD_BEEF; rr_a = 1'b1;
    #1;
    chk("s2_xr_first", 64'(xr_a), 64'h4);
    e.d = 32'hDEAD_BEEF; e.i = 2'd2; q_a.push_back(e);
    tick();
    chk("s2_rv_first", 64'(rv_a), 64'h1);
    c_a = 2'd1; xv_a = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      x_a[N +: N] = 32'h1111_0000 + 32'(k);
      #1;
      chk("s2_xr_stream", 64'(xr_a), 64'h2);
      e.d = 32'h1111_0000 + 32'(k); e.i = 2'd1; q_a.push_back(e);
      tick();
      chk("s2_rv_stream", 64'(rv_a), 64'h1);
    end
    xv_a = 4'h0;
    tick();
    chk("s2_rv_drained", 64'(rv_a), 64'h0);

    // Backpressure: hold for three cycles, then drain and reload on one edge
    c_a = 2'd1; xv_a = 4'b0010; x_a[N +: N] = 32'hCAFE_0001; rr_a = 1'b0;
    e.d = 32'hCAFE_0001; e.i = 2'd1; q_a.push_back(e);
    tick();
    xv_a = 4'hF; x_a[N +: N] = 32'hCAFE_0002;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("s3_xr_stall", 64'(xr_a), 64'h0);
      chk("s3_r_hold", 64'(r_a), 64'hCAFE_0001);
      chk("s3_ri_hold", 64'(ri_a), 64'h1);
      chk("s3_rv_hold", 64'(rv_a), 64'h1);
      tick();
    end
    rr_a = 1'b1;
    #1;
    chk("s3_xr_release", 64'(xr_a), 64'h2);
    e.d = 32'hCAFE_0002; e.i = 2'd1; q_a.push_back(e);
    tick();
    chk("s3_rv_reload", 64'(rv_a), 64'h1);
    chk("s3_r_reload", 64'(r_a), 64'hCAFE_0002);
    xv_a = 4'h0;
    tick();
    chk("s3_rv_drained", 64'(rv_a), 64'h0);

    // Out-of-range select on the three-channel instance
    c_b = 2'd0; xv_b = 3'b001; x_b[0 +: N] = 32'hB0B0_0001; rr_b = 1'b1;
    e.d = 32'hB0B0_0001; e.i = 2'd0; q_b.push_back(e);
    tick();
    c_b = 2'd3; xv_b = 3'b111;
    #1;
    chk("s4_xr_oor", 64'(xr_b), 64'h0);
    tick();
    chk("s4_rv_fall", 64'(rv_b), 64'h0);
    tick();
    chk("s4_rv_noload", 64'(rv_b), 64'h0);
    chk("s4_xr_oor2", 64'(xr_b), 64'h0);
    xv_b = 3'b000;

    // Round-robin fairness: all valid, then only channels 0 and 3
    for (int ch = 0; ch < 4; ch++) x_m[ch*N +: N] = 32'h5000_0000 + 32'(ch);
    xv_m = 4'hF; rr_m = 1'b1;
    #1;
    chk("s5_xr_first", 64'(xr_m), 64'h1);
    for (int k = 0; k < 5; k++) begin
      e.d = 32'h5000_0000 + 32'(k % 4); e.i = 2'(k % 4); q_m.push_back(e);
    end
    repeat (5) tick();
    xv_m = 4'b1001;
    e.d = 32'h5000_0003; e.i = 2'd3; q_m.push_back(e);
    e.d = 32'h5000_0000; e.i = 2'd0; q_m.push_back(e);
    e.d = 32'h5000_0003; e.i = 2'd3; q_m.push_back(e);
    e.d = 32'h5000_0000; e.i = 2'd0; q_m.push_back(e);
    repeat (4) tick();
    xv_m = 4'h0;
    tick();
    chk("s5_rv_drained", 64'(rv_m), 64'h0);

    // Reset while stalled: held result is dropped and the pointer returns to 0
    x_m[2*N +: N] = 32'h6666_0002; xv_m = 4'b0100; rr_m = 1'b0;
    tick();
    chk("s6_rv_loaded", 64'(rv_m), 64'h1);
    chk("s6_ri_loaded", 64'(ri_m), 64'h2);
    chk("s6_r_loaded", 64'(r_m), 64'h6666_0002);
    rst_n = 1'b0;
    #1;
    chk("s6_xr_in_reset", 64'(xr_m), 64'h0);
    tick();
    chk("s6_rv_after_rst", 64'(rv_m), 64'h0);
    chk("s6_r_after_rst", 64'(r_m), 64'h0);
    chk("s6_ri_after_rst", 64'(ri_m), 64'h0);
    rst_n = 1'b1;
    x_m[2*N +: N] = 32'h5000_0002; xv_m = 4'hF; rr_m = 1'b1;
    e.d = 32'h5000_0000; e.i = 2'd0; q_m.push_back(e);
    tick();
    chk("s6_rv_post", 64'(rv_m), 64'h1);
    xv_m = 4'h0;
    tick();
    chk("s6_rv_drained", 64'(rv_m), 64'h0);

    tick();
    chk("a_queue_empty", 64'(q_a.size()), 64'h0);
    chk("b_queue_empty", 64'(q_b.size()), 64'h0);
    chk("m_queue_empty", 64'(q_m.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
